mc_control_fsm: RTL and testbench

//  Parametrised multicycle control FSM for the datapath; successor to the fixed-timing controller.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_wait_counter.sv | 27 ++
 rtl/mc_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and datapath selects.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_IF       = 4'd1,
      ST_ID       = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_EXEC_I   = 4'd4,
      ST_EXEC_MUL = 4'd5,
      ST_ADDR_LD  = 4'd6,
      ST_ADDR_ST  = 4'd7,
      ST_MEM_LD   = 4'd8,
      ST_MEM_ST   = 4'd9,
      ST_WB_ALU   = 4'd10,
      ST_WB_MEM   = 4'd11,
      ST_BRANCH   = 4'd12,
      ST_ERROR    = 4'd13
   } state_t;

   localparam int OP_NOP  = 0;
   localparam int OP_ADD  = 1;
   localparam int OP_ADDI = 2;
   localparam int OP_SUB  = 3;
   localparam int OP_MOV  = 4;
   localparam int OP_LR   = 5;
   localparam int OP_SR   = 6;
   localparam int OP_LA   = 7;
   localparam int OP_BLEQ = 8;
   localparam int OP_MUL  = 9;

   localparam logic [2:0] ALU_OP_ADD   = 3'd0;
   localparam logic [2:0] ALU_OP_SUB   = 3'd1;
   localparam logic [2:0] ALU_OP_MUL   = 3'd2;
   localparam logic [2:0] ALU_OP_PASSA = 3'd3;
   localparam logic [2:0] ALU_OP_PASSB = 3'd4;

   localparam logic [1:0] PC_SELECT_RESET   = 2'd0;
   localparam logic [1:0] PC_SELECT_ALU     = 2'd1;
   localparam logic [1:0] PC_SELECT_ALU_BUF = 2'd2;

   localparam logic       ALU_SRC_A_PC  = 1'b0;
   localparam logic       ALU_SRC_A_REG = 1'b1;
   localparam logic [1:0] ALU_SRC_B_REG    = 2'd0;
   localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
   localparam logic [1:0] ALU_SRC_B_BRANCH = 2'd3;

   localparam logic REG_DST_RN = 1'b0;
   localparam logic REG_DST_RD = 1'b1;
   localparam logic MEM_TO_REG_ALU = 1'b0;
   localparam logic MEM_TO_REG_MEM = 1'b1;

endpackage

// File: rtl/mc_wait_counter.sv
// Saturating down-counter shared by the MUL latency and memory-timeout sequencing.
module mc_wait_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory wait states, memory timeout, multi-cycle MUL and a sticky ERROR state.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int OPCODE_W    = 4,
   parameter int MUL_LATENCY = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                RegDst,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [2:0]          ALUOp,
   output logic                RegWrite,
   output logic                MemToReg,
   output logic                IRWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                mem_select,
   output logic [1:0]          PCSource,
   output logic                mem_req,
   output logic                illegal_op,
   output logic [3:0]          state_dbg
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] MEM_LOAD = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   state_t           state, next_state;
   logic             cnt_load, cnt_zero, timeout_hit;
   logic [CNT_W-1:0] cnt_load_val;
   logic op_nop, op_add, op_addi, op_sub, op_mov, op_lr, op_sr, op_la, op_bleq, op_mul;

   assign op_nop  = (opcode == OPCODE_W'(OP_NOP));
   assign op_add  = (opcode == OPCODE_W'(OP_ADD));
   assign op_addi = (opcode == OPCODE_W'(OP_ADDI));
   assign op_sub  = (opcode == OPCODE_W'(OP_SUB));
   assign op_mov  = (opcode == OPCODE_W'(OP_MOV));
   assign op_lr   = (opcode == OPCODE_W'(OP_LR));
   assign op_sr   = (opcode == OPCODE_W'(OP_SR));
   assign op_la   = (opcode == OPCODE_W'(OP_LA));
   assign op_bleq = (opcode == OPCODE_W'(OP_BLEQ));
   assign op_mul  = (opcode == OPCODE_W'(OP_MUL));

   // Counter reloads on every state change with the budget of the state being entered.
   assign cnt_load    = (next_state != state);
   assign timeout_hit = (MEM_TIMEOUT != 0) && cnt_zero;

   always_comb begin
      cnt_load_val = '0;
      case (next_state)
         ST_EXEC_MUL:                 cnt_load_val = MUL_LOAD;
         ST_IF, ST_MEM_LD, ST_MEM_ST: cnt_load_val = MEM_LOAD;
         default:                     cnt_load_val = '0;
      endcase
   end

   mc_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (!cnt_load),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_RESET;
      else        state <= next_state;
   end

   // Memory handshake: mem_req stays high for the whole wait state; the access
   // completes in the cycle mem_ready=1, and mem_ready wins over a same-cycle timeout.
   always_comb begin
      next_state = ST_ERROR;
      case (state)
         ST_RESET:    next_state = ST_IF;
         ST_IF:       next_state = mem_ready ? ST_ID : (timeout_hit ? ST_ERROR : ST_IF);
         ST_ID: begin
            if (op_nop)                         next_state = ST_IF;
            else if (op_add || op_sub || op_mov) next_state = ST_EXEC_R;
            else if (op_addi || op_la)          next_state = ST_EXEC_I;
            else if (op_mul)                    next_state = ST_EXEC_MUL;
            else if (op_lr)                     next_state = ST_ADDR_LD;
            else if (op_sr)                     next_state = ST_ADDR_ST;
            else if (op_bleq)                   next_state = ST_BRANCH;
            else                                next_state = ST_ERROR;
         end
         ST_EXEC_R:   next_state = ST_WB_ALU;
         ST_EXEC_I:   next_state = ST_WB_ALU;
         ST_EXEC_MUL: next_state = cnt_zero ? ST_WB_ALU : ST_EXEC_MUL;
         ST_ADDR_LD:  next_state = ST_MEM_LD;
         ST_ADDR_ST:  next_state = ST_MEM_ST;
         ST_MEM_LD:   next_state = mem_ready ? ST_WB_MEM : (timeout_hit ? ST_ERROR : ST_MEM_LD);
         ST_MEM_ST:   next_state = mem_ready ? ST_IF : (timeout_hit ? ST_ERROR : ST_MEM_ST);
         ST_WB_ALU:   next_state = ST_IF;
         ST_WB_MEM:   next_state = ST_IF;
         ST_BRANCH:   next_state = ST_IF;
         default:     next_state = ST_ERROR;
      endcase
   end

   always_comb begin
      RegDst      = REG_DST_RN;
      ALUSrcA     = ALU_SRC_A_PC;
      ALUSrcB     = ALU_SRC_B_REG;
      ALUOp       = ALU_OP_ADD;
      RegWrite    = 1'b0;
      MemToReg    = MEM_TO_REG_ALU;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      mem_select  = 1'b0;
      PCSource    = PC_SELECT_RESET;
      mem_req     = 1'b0;
      illegal_op  = 1'b0;
      case (state)
         ST_RESET: begin
            MemRead = 1'b1;
            PCWrite = 1'b1;
         end
         ST_IF: begin
            mem_req  = 1'b1;
            MemRead  = 1'b1;
            ALUSrcB  = ALU_SRC_B_FOUR;
            PCSource = PC_SELECT_ALU;
            IRWrite  = mem_ready;
            PCWrite  = mem_ready;
         end
         ST_ID: ALUSrcB = ALU_SRC_B_BRANCH;
         ST_EXEC_R: begin
            ALUSrcA = ALU_SRC_A_REG;
            RegDst  = REG_DST_RD;
            if (op_sub)      ALUOp = ALU_OP_SUB;
            else if (op_mov) ALUOp = ALU_OP_PASSA;
         end
         ST_EXEC_I: begin
            ALUSrcA = ALU_SRC_A_REG;
            ALUSrcB = ALU_SRC_B_IMM;
            if (op_la) ALUOp = ALU_OP_PASSB;
         end
         ST_EXEC_MUL: begin
            ALUSrcA = ALU_SRC_A_REG;
            ALUOp   = ALU_OP_MUL;
         end
         ST_ADDR_LD, ST_ADDR_ST: begin
            ALUSrcA = ALU_SRC_A_REG;
            ALUSrcB = ALU_SRC_B_IMM;
         end
         ST_MEM_LD: begin
            mem_req    = 1'b1;
            MemRead    = 1'b1;
            mem_select = 1'b1;
         end
         ST_MEM_ST: begin
            mem_req    = 1'b1;
            MemWrite   = 1'b1;
            mem_select = 1'b1;
         end
         ST_WB_ALU: begin
            RegWrite = 1'b1;
            RegDst   = (op_add || op_sub || op_mov) ? REG_DST_RD : REG_DST_RN;
         end
         ST_WB_MEM: begin
            RegWrite   = 1'b1;
            MemToReg   = MEM_TO_REG_MEM;
            mem_select = 1'b1;
         end
         ST_BRANCH: begin
            ALUSrcA     = ALU_SRC_A_REG;
            ALUOp       = ALU_OP_SUB;
            PCWriteCond = 1'b1;
            PCWrite     = alu_zero;
            PCSource    = PC_SELECT_ALU_BUF;
         end
         default: illegal_op = 1'b1;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle expected output words queued by the driver, checked by a monitor.
module tb_mc_control_fsm;
   import mc_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       req, mrd, mwr, irw, pcw, pcwc;
      logic [1:0] pcs;
      logic       rw, rd, m2r;
      logic [2:0] aop;
      logic       asa;
      logic [1:0] asb;
      logic       msel, ill;
   } out_t;
   localparam int W = $bits(out_t);

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic       alu_zero, mem_ready;
   logic       RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemRead, MemWrite;
   logic       PCWrite, PCWriteCond, mem_select, mem_req, illegal_op;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic [3:0] state_dbg;

   logic [W-1:0] exp_q[$];
   string        lbl_q[$];
   logic [W-1:0] exp_w, got_w;
   string        lbl;
   int           n_checks = 0;
   int           n_pass = 0;

   mc_control_fsm #(.OPCODE_W(4), .MUL_LATENCY(4), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegWrite(RegWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .mem_select(mem_select), .PCSource(PCSource), .mem_req(mem_req),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   // clock/reset block
   always #5 clk = ~clk;

   assign got_w = {state_dbg, mem_req, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                   PCSource, RegWrite, RegDst, MemToReg, ALUOp, ALUSrcA, ALUSrcB,
                   mem_select, illegal_op};

   // hand-written expected output words, one per state flavour
   function automatic out_t e_rst();
      out_t e = '0;
      e.st = ST_RESET; e.mrd = 1'b1; e.pcw = 1'b1; e.pcs = 2'd0;
      return e;
   endfunction
   function automatic out_t e_if(input logic rdy);
      out_t e = '0;
      e.st = ST_IF; e.req = 1'b1; e.mrd = 1'b1; e.irw = rdy; e.pcw = rdy;
      e.pcs = 2'd1; e.asa = 1'b0; e.asb = 2'd1; e.aop = 3'd0;
      return e;
   endfunction
   function automatic out_t e_id();
      out_t e = '0;
      e.st = ST_ID; e.asa = 1'b0; e.asb = 2'd3; e.aop = 3'd0;
      return e;
   endfunction
   function automatic out_t e_exr(input logic [2:0] aop);
      out_t e = '0;
      e.st = ST_EXEC_R; e.asa = 1'b1; e.asb = 2'd0; e.rd = 1'b1; e.aop = aop;
      return e;
   endfunction
   function automatic out_t e_exi(input logic [2:0] aop);
      out_t e = '0;
      e.st = ST_EXEC_I; e.asa = 1'b1; e.asb = 2'd2; e.rd = 1'b0; e.aop = aop;
      return e;
   endfunction
   function automatic out_t e_mul();
      out_t e = '0;
      e.st = ST_EXEC_MUL; e.asa = 1'b1; e.asb = 2'd0; e.aop = 3'd2;
      return e;
   endfunction
   function automatic out_t e_addr(input logic [3:0] st);
      out_t e = '0;
      e.st = st; e.asa = 1'b1; e.asb = 2'd2; e.aop = 3'd0;
      return e;
   endfunction
   function automatic out_t e_mem(input logic [3:0] st, input logic wr);
      out_t e = '0;
      e.st = st; e.req = 1'b1; e.mrd = ~wr; e.mwr = wr; e.msel = 1'b1;
      return e;
   endfunction
   function automatic out_t e_wb_alu(input logic rd);
      out_t e = '0;
      e.st = ST_WB_ALU; e.rw = 1'b1; e.m2r = 1'b0; e.rd = rd;
      return e;
   endfunction
   function automatic out_t e_wb_mem();
      out_t e = '0;
      e.st = ST_WB_MEM; e.rw = 1'b1; e.m2r = 1'b1; e.rd = 1'b0; e.msel = 1'b1;
      return e;
   endfunction
   function automatic out_t e_br(input logic z);
      out_t e = '0;
      e.st = ST_BRANCH; e.asa = 1'b1; e.asb = 2'd0; e.aop = 3'd1;
      e.pcwc = 1'b1; e.pcw = z; e.pcs = 2'd2;
      return e;
   endfunction
   function automatic out_t e_err();
      out_t e = '0;
      e.st = ST_ERROR; e.ill = 1'b1;
      return e;
   endfunction

   // driver tasks: apply inputs just after a rising edge, queue what the DUT must show this cycle
   task automatic cyc(input logic [3:0] op, input logic rdy, input logic z, input out_t e, input string l);
      opcode = op; mem_ready = rdy; alu_zero = z;
      exp_q.push_back(e);
      lbl_q.push_back(l);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(4'd0, 1'b0, 1'b0, e_rst(), "reset");
      cyc(4'd0, 1'b0, 1'b0, e_rst(), "reset_hold");
      reset = 1'b1;
      cyc(4'd0, 1'b0, 1'b0, e_rst(), "reset_release");
   endtask

   task automatic do_fetch(input logic [3:0] op, input int waits);
      for (int i = 0; i < waits; i++) cyc(op, 1'b0, 1'b0, e_if(1'b0), "if_wait");
      cyc(op, 1'b1, 1'b0, e_if(1'b1), "if_ready");
      cyc(op, 1'b0, 1'b0, e_id(), "id");
   endtask

   task automatic do_alu(input logic [3:0] op, input out_t ex, input logic rd);
      do_fetch(op, 0);
      cyc(op, 1'b0, 1'b0, ex, "exec");
      cyc(op, 1'b0, 1'b0, e_wb_alu(rd), "wb_alu");
   endtask

   task automatic do_sr(input int waits, input logic last_rdy);
      do_fetch(4'(OP_SR), 0);
      cyc(4'(OP_SR), 1'b0, 1'b0, e_addr(ST_ADDR_ST), "addr_st");
      for (int i = 0; i < waits; i++) cyc(4'(OP_SR), 1'b0, 1'b0, e_mem(ST_MEM_ST, 1'b1), "mem_st_wait");
      cyc(4'(OP_SR), last_rdy, 1'b0, e_mem(ST_MEM_ST, 1'b1), "mem_st_last");
   endtask

   task automatic err_cycles(input int n);
      for (int i = 0; i < n; i++)
         cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, e_err(), "err_sticky");
   endtask

   // scoreboard monitor: compares on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         lbl   = lbl_q.pop_front();
         n_checks++;
         if (got_w === exp_w) n_pass++;
         else $display("FAIL %s @%0t: got %h required %h", lbl, $time, got_w, exp_w);
      end
   end

   initial begin
      reset = 1'b0; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // ADD fetched with mem_ready three cycles late
      do_fetch(4'(OP_ADD), 3);
      cyc(4'(OP_ADD), 1'b0, 1'b0, e_exr(3'd0), "exec_add");
      cyc(4'(OP_ADD), 1'b0, 1'b0, e_wb_alu(1'b1), "wb_add");

      do_alu(4'(OP_SUB),  e_exr(3'd1), 1'b1);
      do_alu(4'(OP_MOV),  e_exr(3'd3), 1'b1);
      do_alu(4'(OP_ADDI), e_exi(3'd0), 1'b0);
      do_alu(4'(OP_LA),   e_exi(3'd4), 1'b0);

      // MUL: exactly four EXEC_MUL cycles
      do_fetch(4'(OP_MUL), 0);
      for (int i = 0; i < 4; i++) cyc(4'(OP_MUL), 1'b0, 1'b0, e_mul(), "exec_mul");
      cyc(4'(OP_MUL), 1'b0, 1'b0, e_wb_alu(1'b0), "wb_mul");

      do_fetch(4'(OP_BLEQ), 0);
      cyc(4'(OP_BLEQ), 1'b0, 1'b1, e_br(1'b1), "bleq_taken");
      do_fetch(4'(OP_BLEQ), 0);
      cyc(4'(OP_BLEQ), 1'b0, 1'b0, e_br(1'b0), "bleq_not_taken");

      do_fetch(4'(OP_NOP), 0);

      do_fetch(4'(OP_LR), 0);
      cyc(4'(OP_LR), 1'b0, 1'b0, e_addr(ST_ADDR_LD), "addr_ld");
      cyc(4'(OP_LR), 1'b0, 1'b0, e_mem(ST_MEM_LD, 1'b0), "mem_ld_wait");
      cyc(4'(OP_LR), 1'b0, 1'b0, e_mem(ST_MEM_LD, 1'b0), "mem_ld_wait");
      cyc(4'(OP_LR), 1'b1, 1'b0, e_mem(ST_MEM_LD, 1'b0), "mem_ld_ready");
      cyc(4'(OP_LR), 1'b0, 1'b0, e_wb_mem(), "wb_mem");

      // store completing on the 16th wait cycle, then a store that times out
      do_sr(15, 1'b1);
      do_sr(15, 1'b0);
      cyc(4'd0, 1'b0, 1'b0, e_err(), "st_timeout_err");
      err_cycles(4);
      do_reset();

      do_fetch(4'hF, 0);
      cyc(4'hF, 1'b0, 1'b0, e_err(), "illegal_op_err");
      err_cycles(3);
      do_reset();

      // reset asserted in the middle of a pending load
      do_fetch(4'(OP_LR), 0);
      cyc(4'(OP_LR), 1'b0, 1'b0, e_addr(ST_ADDR_LD), "addr_ld");
      cyc(4'(OP_LR), 1'b0, 1'b0, e_mem(ST_MEM_LD, 1'b0), "mem_ld_req");
      reset = 1'b0;
      cyc(4'(OP_LR), 1'b0, 1'b0, e_rst(), "reset_mid_access");
      reset = 1'b1;
      cyc(4'(OP_LR), 1'b0, 1'b0, e_rst(), "reset_mid_release");
      cyc(4'(OP_LR), 1'b0, 1'b0, e_if(1'b0), "if_after_reset");

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
